// File: rtl/apb_timer_if.sv
// APB bus bundle for the apb_timer slave: select, address, strobes, data and response.
interface apb_timer_if;
    logic        PSEL;
    logic [5:0]  PADDR;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    modport master (
        output PSEL, PADDR, PENABLE, PWRITE, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PSEL, PADDR, PENABLE, PWRITE, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/apb_timer.sv
// Down-counting APB timer with prescaler, auto-reload/one-shot mode and level interrupt.
// Define APB_TIMER_CAPTURE_EN to add the CAPIN input-capture feature.
module apb_timer #(
    parameter int CNT_WIDTH = 32,
    parameter int PRE_WIDTH = 8
) (
    input  logic       PCLK,
    input  logic       PRESET,
`ifdef APB_TIMER_CAPTURE_EN
    input  logic       CAPIN,
`endif
    apb_timer_if.slave apb,
    output logic       TIMERINT
);

    localparam logic [5:0] ADDR_CTRL    = 6'h00;
    localparam logic [5:0] ADDR_LOAD    = 6'h01;
    localparam logic [5:0] ADDR_VALUE   = 6'h02;
    localparam logic [5:0] ADDR_INTSTAT = 6'h03;
    localparam logic [5:0] ADDR_CAPTURE = 6'h04;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [PRE_WIDTH-1:0] PRE_ONE = {{(PRE_WIDTH-1){1'b0}}, 1'b1};

    logic                 en_r, ie_r, oneshot_r, raw_r;
    logic [PRE_WIDTH-1:0] prescale_r, pre_cnt_r;
    logic [CNT_WIDTH-1:0] load_r, value_r;

    logic                 en_nxt_s, raw_nxt_s;
    logic [PRE_WIDTH-1:0] pre_cnt_nxt_s;
    logic [CNT_WIDTH-1:0] value_nxt_s;
    logic                 wr_s, wr_ctrl_s, wr_load_s, wr_value_s, wr_int_s;
    logic                 tick_s, expire_s;
    logic [31:0]          rdata_s;
    logic                 unmapped_s;

    assign wr_s       = apb.PSEL & apb.PENABLE & apb.PWRITE;
    assign wr_ctrl_s  = wr_s & (apb.PADDR == ADDR_CTRL);
    assign wr_load_s  = wr_s & (apb.PADDR == ADDR_LOAD);
    assign wr_value_s = wr_s & (apb.PADDR == ADDR_VALUE);
    assign wr_int_s   = wr_s & (apb.PADDR == ADDR_INTSTAT);

    assign tick_s   = en_r & (pre_cnt_r == prescale_r);
    assign expire_s = tick_s & (value_r == {CNT_WIDTH{1'b0}});

    // Next-state for prescaler, counter, enable and raw flag; bus writes take priority over ticks,
    // except that a fresh expiry beats a simultaneous RAW clear.
    always_comb begin
        pre_cnt_nxt_s = pre_cnt_r;
        value_nxt_s   = value_r;
        en_nxt_s      = en_r;
        raw_nxt_s     = raw_r;

        if (wr_ctrl_s || tick_s) begin
            pre_cnt_nxt_s = {PRE_WIDTH{1'b0}};
        end else if (en_r) begin
            pre_cnt_nxt_s = pre_cnt_r + PRE_ONE;
        end else begin
            pre_cnt_nxt_s = pre_cnt_r;
        end

        if (wr_value_s) begin
            value_nxt_s = apb.PWDATA[CNT_WIDTH-1:0];
        end else if (expire_s) begin
            value_nxt_s = load_r;
        end else if (tick_s) begin
            value_nxt_s = value_r - CNT_ONE;
        end else begin
            value_nxt_s = value_r;
        end

        if (wr_ctrl_s) begin
            en_nxt_s = apb.PWDATA[0];
        end else if (expire_s && oneshot_r) begin
            en_nxt_s = 1'b0;
        end else begin
            en_nxt_s = en_r;
        end

        if (expire_s) begin
            raw_nxt_s = 1'b1;
        end else if (wr_int_s && apb.PWDATA[0]) begin
            raw_nxt_s = 1'b0;
        end else begin
            raw_nxt_s = raw_r;
        end
    end

    // Timer state registers.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            en_r       <= 1'b0;
            ie_r       <= 1'b0;
            oneshot_r  <= 1'b0;
            raw_r      <= 1'b0;
            prescale_r <= {PRE_WIDTH{1'b0}};
            pre_cnt_r  <= {PRE_WIDTH{1'b0}};
            load_r     <= {CNT_WIDTH{1'b0}};
            value_r    <= {CNT_WIDTH{1'b0}};
        end else begin
            en_r      <= en_nxt_s;
            raw_r     <= raw_nxt_s;
            pre_cnt_r <= pre_cnt_nxt_s;
            value_r   <= value_nxt_s;
            if (wr_ctrl_s) begin
                ie_r       <= apb.PWDATA[1];
                oneshot_r  <= apb.PWDATA[2];
                prescale_r <= apb.PWDATA[8 +: PRE_WIDTH];
            end
            if (wr_load_s) begin
                load_r <= apb.PWDATA[CNT_WIDTH-1:0];
            end
        end
    end

`ifdef APB_TIMER_CAPTURE_EN
    logic [1:0]           cap_sync_r;
    logic                 cap_prev_r, capraw_r, capie_r;
    logic [CNT_WIDTH-1:0] capture_r;
    logic                 cap_edge_s;

    assign cap_edge_s = cap_sync_r[1] & ~cap_prev_r;

    // CAPIN synchronizer, edge detector and capture registers; CAPTURE records the
    // counter value committed on the same edge, so it matches what VALUE then reads.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            cap_sync_r <= 2'b00;
            cap_prev_r <= 1'b0;
            capraw_r   <= 1'b0;
            capie_r    <= 1'b0;
            capture_r  <= {CNT_WIDTH{1'b0}};
        end else begin
            cap_sync_r <= {cap_sync_r[0], CAPIN};
            cap_prev_r <= cap_sync_r[1];
            if (wr_ctrl_s) begin
                capie_r <= apb.PWDATA[3];
            end
            if (cap_edge_s) begin
                capture_r <= value_nxt_s;
                capraw_r  <= 1'b1;
            end else if (wr_int_s && apb.PWDATA[1]) begin
                capraw_r <= 1'b0;
            end
        end
    end

    assign TIMERINT = (raw_r & ie_r) | (capraw_r & capie_r);
`else
    assign TIMERINT = raw_r & ie_r;
`endif

    // Read-data mux and unmapped-offset decode.
    always_comb begin
        rdata_s    = 32'h0000_0000;
        unmapped_s = 1'b0;
        case (apb.PADDR)
            ADDR_CTRL: begin
                rdata_s[0] = en_r;
                rdata_s[1] = ie_r;
                rdata_s[2] = oneshot_r;
`ifdef APB_TIMER_CAPTURE_EN
                rdata_s[3] = capie_r;
`endif
                rdata_s[8 +: PRE_WIDTH] = prescale_r;
            end
            ADDR_LOAD:  rdata_s[CNT_WIDTH-1:0] = load_r;
            ADDR_VALUE: rdata_s[CNT_WIDTH-1:0] = value_r;
            ADDR_INTSTAT: begin
                rdata_s[0] = raw_r;
`ifdef APB_TIMER_CAPTURE_EN
                rdata_s[1] = capraw_r;
`endif
            end
`ifdef APB_TIMER_CAPTURE_EN
            ADDR_CAPTURE: rdata_s[CNT_WIDTH-1:0] = capture_r;
`endif
            default: unmapped_s = 1'b1;
        endcase
    end

    assign apb.PRDATA  = (apb.PSEL && !PRESET) ? rdata_s : 32'h0000_0000;
    assign apb.PSLVERR = apb.PSEL & apb.PENABLE & unmapped_s & ~PRESET;
    assign apb.PREADY  = 1'b1;

endmodule

// File: tb/tb_apb_timer.sv
// Directed self-checking bench for apb_timer (default build; capture test when
// APB_TIMER_CAPTURE_EN is defined).
module tb_apb_timer;

    localparam logic [5:0] A_CTRL    = 6'h00;
    localparam logic [5:0] A_LOAD    = 6'h01;
    localparam logic [5:0] A_VALUE   = 6'h02;
    localparam logic [5:0] A_INTSTAT = 6'h03;
    localparam logic [5:0] A_CAPTURE = 6'h04;
    localparam logic [5:0] A_BAD     = 6'h08;

    logic PCLK = 1'b0;
    logic PRESET;
    logic TIMERINT;
    int   checks = 0;
    int   errors = 0;

    apb_timer_if bus ();

`ifdef APB_TIMER_CAPTURE_EN
    logic capin = 1'b0;
`endif

    apb_timer dut (
        .PCLK     (PCLK),
        .PRESET   (PRESET),
`ifdef APB_TIMER_CAPTURE_EN
        .CAPIN    (capin),
`endif
        .apb      (bus.slave),
        .TIMERINT (TIMERINT)
    );

    always #5 PCLK = ~PCLK;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    // Full write; err is PSLVERR in the access phase, post is PRDATA at addr just after commit.
    task automatic apb_write(input logic [5:0] addr, input logic [31:0] data,
                             output logic [31:0] post, output logic err);
        @(posedge PCLK); #1;
        bus.PSEL = 1'b1; bus.PADDR = addr; bus.PWRITE = 1'b1; bus.PWDATA = data; bus.PENABLE = 1'b0;
        @(posedge PCLK); #1;
        bus.PENABLE = 1'b1; #1;
        err = bus.PSLVERR;
        @(posedge PCLK); #1;
        bus.PENABLE = 1'b0; bus.PWRITE = 1'b0; #1;
        post = bus.PRDATA;
        bus.PSEL = 1'b0;
    endtask

    task automatic apb_read(input logic [5:0] addr, output logic [31:0] data,
                            output logic err, output logic rdy);
        @(posedge PCLK); #1;
        bus.PSEL = 1'b1; bus.PADDR = addr; bus.PWRITE = 1'b0; bus.PENABLE = 1'b0;
        @(posedge PCLK); #1;
        bus.PENABLE = 1'b1; #1;
        data = bus.PRDATA; err = bus.PSLVERR; rdy = bus.PREADY;
        @(posedge PCLK); #1;
        bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
    endtask

    // Zero-time look at a register through the combinational read path.
    task automatic peek(input logic [5:0] addr, output logic [31:0] data);
        bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0; bus.PADDR = addr; #1;
        data = bus.PRDATA;
        bus.PSEL = 1'b0;
    endtask

    task automatic test_reset;
        logic [31:0] d; logic e, r;
        PRESET = 1'b1;
        bus.PSEL = 1'b1; bus.PENABLE = 1'b1; bus.PWRITE = 1'b0; bus.PADDR = A_BAD; bus.PWDATA = 32'h0;
        repeat (3) @(posedge PCLK);
        #1;
        checks++; if (TIMERINT !== 1'b0) begin errors++; $display("FAIL rst_int got %b want 0", TIMERINT); end
        checks++; if (bus.PREADY !== 1'b1) begin errors++; $display("FAIL rst_ready got %b want 1", bus.PREADY); end
        checks++; if (bus.PSLVERR !== 1'b0) begin errors++; $display("FAIL rst_slverr got %b want 0", bus.PSLVERR); end
        checks++; if (bus.PRDATA !== 32'h0) begin errors++; $display("FAIL rst_prdata got %h want 0", bus.PRDATA); end
        bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
        PRESET = 1'b0;
        for (int a = 0; a < 4; a++) begin
            apb_read(6'(a), d, e, r);
            checks++; if (d !== 32'h0) begin errors++; $display("FAIL rst_reg%0d got %h want 0", a, d); end
            checks++; if ({e, r} !== 2'b01) begin errors++; $display("FAIL rst_resp%0d got err=%b rdy=%b want 0/1", a, e, r); end
        end
    endtask

    task automatic test_periodic;
        logic [31:0] d; logic e; int exp_v;
        apb_write(A_LOAD, 32'd4, d, e);
        apb_write(A_CTRL, 32'h0000_0003, d, e);
        checks++; if (d !== 32'h3) begin errors++; $display("FAIL per_ctrl got %h want 3", d); end
        peek(A_VALUE, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL per_v0 got %h want 0", d); end
        for (int k = 0; k < 6; k++) begin
            @(posedge PCLK); #1;
            exp_v = (k == 5) ? 4 : 4 - k;
            peek(A_VALUE, d);
            checks++; if (d !== 32'(exp_v)) begin errors++; $display("FAIL per_seq%0d got %h want %h", k, d, exp_v); end
            if (k == 0) begin
                peek(A_INTSTAT, d);
                checks++; if (d !== 32'h1) begin errors++; $display("FAIL per_raw got %h want 1", d); end
                checks++; if (TIMERINT !== 1'b1) begin errors++; $display("FAIL per_int got %b want 1", TIMERINT); end
            end
        end
        apb_write(A_INTSTAT, 32'h1, d, e);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL per_w1c got %h want 0", d); end
        checks++; if (TIMERINT !== 1'b0) begin errors++; $display("FAIL per_int_clr got %b want 0", TIMERINT); end
    endtask

    task automatic test_oneshot;
        logic [31:0] d; logic e; int exp_v;
        apb_write(A_CTRL, 32'h0, d, e);
        apb_write(A_INTSTAT, 32'h1, d, e);
        apb_write(A_LOAD, 32'd2, d, e);
        apb_write(A_VALUE, 32'd2, d, e);
        apb_write(A_CTRL, 32'h0000_0307, d, e);
        checks++; if (d !== 32'h307) begin errors++; $display("FAIL os_ctrl got %h want 307", d); end
        for (int k = 1; k <= 14; k++) begin
            @(posedge PCLK); #1;
            exp_v = (k < 4) ? 2 : (k < 8) ? 1 : (k < 12) ? 0 : 2;
            peek(A_VALUE, d);
            checks++; if (d !== 32'(exp_v)) begin errors++; $display("FAIL os_v%0d got %h want %h", k, d, exp_v); end
            if (k == 11) begin
                peek(A_INTSTAT, d);
                checks++; if (d !== 32'h0) begin errors++; $display("FAIL os_raw_early got %h want 0", d); end
            end
            if (k == 12) begin
                peek(A_INTSTAT, d);
                checks++; if (d !== 32'h1) begin errors++; $display("FAIL os_raw got %h want 1", d); end
                peek(A_CTRL, d);
                checks++; if (d !== 32'h306) begin errors++; $display("FAIL os_en_clr got %h want 306", d); end
                checks++; if (TIMERINT !== 1'b1) begin errors++; $display("FAIL os_int got %b want 1", TIMERINT); end
            end
        end
    endtask

    task automatic test_collide;
        logic [31:0] d; logic e;
        apb_write(A_CTRL, 32'h0, d, e);
        apb_write(A_LOAD, 32'h0, d, e);
        apb_write(A_VALUE, 32'h0, d, e);
        apb_write(A_CTRL, 32'h0000_0003, d, e);
        // LOAD=0, PRESCALE=0: every cycle expires, so this W1C always collides with a set.
        apb_write(A_INTSTAT, 32'h1, d, e);
        checks++; if (d !== 32'h1) begin errors++; $display("FAIL col_w1c got %h want 1", d); end
        checks++; if (TIMERINT !== 1'b1) begin errors++; $display("FAIL col_int got %b want 1", TIMERINT); end
        @(posedge PCLK); #1;
        peek(A_VALUE, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL col_load0 got %h want 0", d); end
        apb_write(A_VALUE, 32'h10, d, e);
        checks++; if (d !== 32'h10) begin errors++; $display("FAIL col_vwr got %h want 10", d); end
        @(posedge PCLK); #1;
        peek(A_VALUE, d);
        checks++; if (d !== 32'hF) begin errors++; $display("FAIL col_vdec got %h want f", d); end
    endtask

    task automatic test_unmapped;
        logic [31:0] d; logic e, r;
        apb_write(A_CTRL, 32'h0, d, e);
        apb_write(A_LOAD, 32'h55, d, e);
        apb_write(A_VALUE, 32'h77, d, e);
        apb_write(A_BAD, 32'hFFFF_FFFF, d, e);
        checks++; if (e !== 1'b1) begin errors++; $display("FAIL um_wr_err got %b want 1", e); end
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL um_wr_rd got %h want 0", d); end
        peek(A_LOAD, d);
        checks++; if (d !== 32'h55) begin errors++; $display("FAIL um_load got %h want 55", d); end
        peek(A_VALUE, d);
        checks++; if (d !== 32'h77) begin errors++; $display("FAIL um_value got %h want 77", d); end
        peek(A_CTRL, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL um_ctrl got %h want 0", d); end
        apb_read(A_BAD, d, e, r);
        checks++; if ({d, e} !== {32'h0, 1'b1}) begin errors++; $display("FAIL um_rd got %h err=%b want 0 err=1", d, e); end
        apb_read(A_LOAD, d, e, r);
        checks++; if ({d, e} !== {32'h55, 1'b0}) begin errors++; $display("FAIL um_ok got %h err=%b want 55 err=0", d, e); end
`ifndef APB_TIMER_CAPTURE_EN
        apb_read(A_CAPTURE, d, e, r);
        checks++; if ({d, e} !== {32'h0, 1'b1}) begin errors++; $display("FAIL um_cap got %h err=%b want 0 err=1", d, e); end
`endif
    endtask

    task automatic test_reset_mid;
        logic [31:0] d; logic e;
        apb_write(A_CTRL, 32'h0000_0003, d, e);
        checks++; if (TIMERINT !== 1'b1) begin errors++; $display("FAIL rm_pre_int got %b want 1", TIMERINT); end
        @(posedge PCLK); #1;
        PRESET = 1'b1;
        @(posedge PCLK); #1;
        checks++; if (TIMERINT !== 1'b0) begin errors++; $display("FAIL rm_int got %b want 0", TIMERINT); end
        PRESET = 1'b0;
        peek(A_VALUE, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL rm_value got %h want 0", d); end
        peek(A_CTRL, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL rm_ctrl got %h want 0", d); end
        peek(A_INTSTAT, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL rm_raw got %h want 0", d); end
    endtask

`ifdef APB_TIMER_CAPTURE_EN
    task automatic test_capture;
        logic [31:0] d; logic e;
        apb_write(A_LOAD, 32'h1000, d, e);
        apb_write(A_CTRL, 32'h0000_0001, d, e);
        apb_write(A_INTSTAT, 32'h1, d, e);
        apb_write(A_VALUE, 32'h100, d, e);
        checks++; if (d !== 32'h100) begin errors++; $display("FAIL cap_v got %h want 100", d); end
        capin = 1'b1;
        repeat (2) @(posedge PCLK);
        #1;
        peek(A_CAPTURE, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL cap_early got %h want 0", d); end
        @(posedge PCLK); #1;
        peek(A_CAPTURE, d);
        checks++; if (d !== 32'hFD) begin errors++; $display("FAIL cap_val got %h want fd", d); end
        peek(A_INTSTAT, d);
        checks++; if (d !== 32'h2) begin errors++; $display("FAIL cap_raw got %h want 2", d); end
        checks++; if (TIMERINT !== 1'b0) begin errors++; $display("FAIL cap_int_off got %b want 0", TIMERINT); end
        apb_write(A_CTRL, 32'h0000_0009, d, e);
        checks++; if (TIMERINT !== 1'b1) begin errors++; $display("FAIL cap_int_on got %b want 1", TIMERINT); end
    endtask
`endif

    initial begin
        bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0;
        bus.PADDR = 6'h00; bus.PWDATA = 32'h0;
        test_reset();
        test_periodic();
        test_oneshot();
        test_collide();
        test_unmapped();
        test_reset_mid();
`ifdef APB_TIMER_CAPTURE_EN
        test_capture();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/apb_timer.md
Name: apb_timer

Overview:
- 32-bit down-counting APB timer with an 8-bit prescaler, auto-reload or one-shot mode, and a level interrupt.
- Sits downstream of the APB slave mux on port 3 (PADDR[15:12]=4'h3), beside the UART and GPIO slaves.
- Consumes the PCLK-domain APB bus and drives one interrupt bit into the apb_interrupt vector.

Parameters:
- CNT_WIDTH, 32, width of LOAD/VALUE registers and counter (8..32).
- PRE_WIDTH, 8, width of the prescaler field and counter.

Ports:
- PCLK  input  1  APB clock; the only clock.
- PRESET  input  1  synchronous, active-high reset, sampled on PCLK rising edge.
- PSEL  input  1  slave select from the APB slave mux.
- PADDR  input  6  word address, PADDR[7:2].
- PENABLE  input  1  APB access phase.
- PWRITE  input  1  1 = write.
- PWDATA  input  32  write data.
- PRDATA  output  32  read data.
- PREADY  output  1  always 1; no wait states.
- PSLVERR  output  1  error response.
- TIMERINT  output  1  interrupt, level, active-high.

Behaviour:
- Register map (byte offset):
  - 0x00 CTRL: [0] EN, [1] IE, [2] ONESHOT, [15:8] PRESCALE, other bits RAZ/WI.
  - 0x04 LOAD: RW.
  - 0x08 VALUE: RW; a write loads the counter directly.
  - 0x0C INTSTAT: [0] RAW, write-1-to-clear.
  - 0x10 CAPTURE: RO, optional feature only.
- Write commits on the PCLK edge where PSEL & PENABLE & PWRITE are all 1.
- Read: PRDATA is combinational from PADDR while PSEL = 1, else 0.
- PSLVERR = PSEL & PENABLE & (offset is unmapped). Unmapped writes have no effect.
- Reset (PRESET = 1): all registers, prescaler counter, PRDATA, PSLVERR and TIMERINT are 0. PREADY is 1.
- Prescaler: pre_cnt increments every cycle while EN = 1.
  - When pre_cnt == PRESCALE: one-cycle tick, then pre_cnt returns to 0.
  - Tick rate is PCLK / (PRESCALE+1).
  - Any CTRL write clears pre_cnt.
- On tick:
  - VALUE != 0: VALUE decrements.
  - VALUE == 0: VALUE <= LOAD and RAW <= 1. If ONESHOT = 1, EN clears in the same cycle.
  - Period = (LOAD+1)*(PRESCALE+1) PCLK cycles.
- EN = 0: VALUE and pre_cnt hold; no ticks.
- LOAD = 0 with EN = 1 and PRESCALE = 0: RAW sets every cycle (continuous).
- TIMERINT = RAW & IE, combinational from registered state, no added latency.
- Simultaneous events:
  - A VALUE write and a tick in the same cycle: the write wins.
  - A W1C of RAW and a new set in the same cycle: the set wins (RAW = 1).
  - A CTRL write setting EN in the same cycle as a one-shot expiry: the written value wins.
- Reset mid-count: all state returns to 0 on the next edge. No pending interrupt survives.

Optional Feature:
- Macro: APB_TIMER_CAPTURE_EN.
- Defined:
  - Adds input port CAPIN (1 bit, asynchronous), a 2-flop synchronizer, and a rising-edge detector.
  - On a detected edge, CAPTURE <= VALUE and INTSTAT[1] CAPRAW <= 1 (W1C, set wins).
  - CTRL[3] CAPIE is added. TIMERINT = (RAW & IE) | (CAPRAW & CAPIE).
  - Edge-to-CAPTURE latency is 3 PCLK cycles.
- Undefined: no CAPIN port. Offset 0x10 is unmapped (PSLVERR = 1). INTSTAT[1] and CTRL[3] are RAZ/WI.

Test Plan:
- Reset, then read 0x00/0x04/0x08/0x0C -> all return 0, TIMERINT = 0, PREADY = 1 throughout.
- Write LOAD = 4, CTRL = 0x0003 (PRESCALE = 0) -> VALUE sequence 0,4,3,2,1,0,4 with RAW first set after 1 cycle; TIMERINT high; a W1C to 0x0C drops it the next cycle.
- LOAD = 2, CTRL = 0x0307 (PRESCALE = 3, one-shot) -> VALUE decrements every 4 cycles; on expiry RAW = 1, EN reads 0, VALUE holds 2 afterwards.
- Time a W1C to 0x0C in the same cycle as an expiry tick -> RAW stays 1. Write VALUE = 0x10 in a tick cycle -> VALUE reads 0x10.
- Read/write offset 0x20 -> PSLVERR = 1 in the access phase, PRDATA = 0, no register changes. Assert PRESET while counting -> VALUE = 0, EN = 0, TIMERINT = 0 next cycle.
- Capture (APB_TIMER_CAPTURE_EN defined): CAPIN rising edge while VALUE = 0x100 and free-running with PRESCALE = 0 -> CAPTURE = 0x0FD, CAPRAW = 1; TIMERINT rises only if CAPIE = 1.
